// File: rtl/rca_16_inverse_serial.sv
// rca_16_inverse_serial: bit-serial subtractor recovering b = s - a, LSB first.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, s[WIDTH:0], a;
//        out_valid/out_ready, b, err (result outside 0..2^WIDTH-1).
module rca_16_inverse_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH:0]  s_sh;
    logic [WIDTH:0]  a_sh;
    logic [WIDTH:0]  res;
    logic [WIDTH:0]  res_nxt;
    logic            borrow;
    logic            borrow_nxt;
    logic            d;
    logic            last;
    logic [CW-1:0]   cnt;

    // One full-subtractor slice on the current LSBs.
    assign d          = s_sh[0] ^ a_sh[0] ^ borrow;
    assign borrow_nxt = (~s_sh[0] & a_sh[0])
                      | (~s_sh[0] & borrow)
                      | (a_sh[0] & borrow);
    assign res_nxt    = {d, res[WIDTH:1]};
    assign last       = (cnt == CW'(WIDTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)  state_nxt = RUN;
            RUN:  if (last)      state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_sh   <= '0;
            a_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            b      <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_sh   <= s;
                        a_sh   <= {1'b0, a};
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    s_sh   <= s_sh >> 1;
                    a_sh   <= a_sh >> 1;
                    res    <= res_nxt;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // Bit WIDTH set or a borrow out both mean out of range.
                        b   <= res_nxt[WIDTH-1:0];
                        err <= res_nxt[WIDTH] | borrow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_16_inverse_serial.sv
// tb_rca_16_inverse_serial: directed checks of the serial inverse adder.
// Drives and samples 1 time unit after each rising edge.
module tb_rca_16_inverse_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] s;
    logic [15:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] b;
    logic        err;

    int checks;
    int errors;

    rca_16_inverse_serial #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single edge.
    task automatic send(input logic [16:0] sv, input logic [15:0] av);
        in_valid = 1'b1;
        s        = sv;
        a        = av;
        step();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid; 99 if it never rises.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        if (!out_valid) cyc = 99;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (b !== 16'h0000) begin
            errors++;
            $display("FAIL reset_b got %h want 0000", b);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err);
        end
    endtask

    task automatic test_op(input string nm, input logic [16:0] sv,
                           input logic [15:0] av, input logic [15:0] eb,
                           input logic ee);
        int cyc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_pre got %b want 1", nm, in_ready);
        end
        send(sv, av);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_run got %b want 0", nm, in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL %s_latency got %0d want 17", nm, cyc);
        end
        checks++;
        if (b !== eb) begin
            errors++;
            $display("FAIL %s_b got %h want %h", nm, b, eb);
        end
        checks++;
        if (err !== ee) begin
            errors++;
            $display("FAIL %s_err got %b want %b", nm, err, ee);
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_post got rdy=%b vld=%b want rdy=1 vld=0",
                     nm, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        send(17'h0ABCD, 16'h1234);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            s = 17'($urandom);
            a = 16'($urandom);
            step();
            cyc++;
        end
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL bp_latency got %0d want 17", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            s = 17'($urandom);
            a = 16'($urandom);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b want vld=1 rdy=0",
                         i, out_valid, in_ready);
            end
            checks++;
            if (b !== 16'h9999 || err !== 1'b0) begin
                errors++;
                $display("FAIL bp_data_%0d got b=%h err=%b want b=9999 err=0",
                         i, b, err);
            end
            step();
        end
        release_out();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0",
                     in_ready, out_valid);
        end
        checks++;
        if (b !== 16'h9999) begin
            errors++;
            $display("FAIL bp_b_hold got %h want 9999", b);
        end
    endtask

    task automatic test_reset_mid_run();
        // Borrow stays set across every bit of this operation.
        send(17'h00000, 16'hFFFF);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got vld=%b rdy=%b want vld=0 rdy=1",
                     out_valid, in_ready);
        end
        checks++;
        if (b !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_data got b=%h err=%b want b=0000 err=0",
                     b, err);
        end
        test_op("after_rst", 17'h00003, 16'h0001, 16'h0002, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = '0;
        a         = '0;
        test_reset();
        test_op("basic",  17'h068AC, 16'h1234, 16'h5678, 1'b0);
        test_op("carry1", 17'h1FFFE, 16'hFFFF, 16'hFFFF, 1'b0);
        test_op("carry2", 17'h10000, 16'h0001, 16'hFFFF, 1'b0);
        test_op("under",  17'h00000, 16'h0001, 16'hFFFF, 1'b1);
        test_op("over",   17'h10000, 16'h0000, 16'h0000, 1'b1);
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
